// File: rtl/jtriders_objdma_pkg.sv
// Shared types and constants for the object-priority DMA and its bus arbiter.
package jtriders_objdma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WT,
    CMP,
    WR,
    NX,
    FIN
  } state_t;

  // Active-low data strobes: none, low byte lane only, both lanes
  localparam logic [1:0] DSN_NONE = 2'b11;
  localparam logic [1:0] DSN_LO   = 2'b10;
  localparam logic [1:0] DSN_BOTH = 2'b00;

endpackage

// File: rtl/jtriders_objdma_arb.sv
// 68000 bus ownership for the DMA: BRn/BGACKn handshake, queued restart and abort.
module jtriders_objdma_arb
  import jtriders_objdma_pkg::*;
(
  input  logic   clk,
  input  logic   rstn,
  input  logic   start,
  input  logic   abort,
  input  logic   BGn,
  input  logic   fin_step,
  input  state_t state,
  output logic   BRn,
  output logic   BGACKn,
  output logic   busy,
  output logic   grant,
  output logic   abort_go,
  output logic   restart
);

  logic pending;

  assign abort_go = abort && (state != IDLE);
  assign grant    = (state == REQ) && !BGn && !abort_go;
  // A start coinciding with the final step is folded straight into the restart
  assign restart  = pending || start;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      BRn     <= 1'b1;
      BGACKn  <= 1'b1;
      busy    <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (abort_go) begin
        BRn    <= 1'b1;
        BGACKn <= 1'b1;
        busy   <= 1'b0;
      end else if (state == IDLE) begin
        if (start) begin
          BRn  <= 1'b0;
          busy <= 1'b1;
        end
      end else if (grant) begin
        BRn    <= 1'b1;
        BGACKn <= 1'b0;
      end else if (fin_step) begin
        BGACKn <= 1'b1;
        BRn    <= !restart;
        busy   <= restart;
      end

      if (abort_go || fin_step)
        pending <= 1'b0;
      else if (start && (state != IDLE))
        pending <= 1'b1;
    end
  end

endmodule

// File: rtl/jtriders_objprio_dma.sv
// Object-priority DMA: walks every record once per logical priority level and
// stamps an ascending hardware priority into the records whose level matches.
module jtriders_objprio_dma
  import jtriders_objdma_pkg::*;
#(
  parameter int AW       = 13,
  parameter int ENTRIES  = 128,
  parameter int STRIDE   = 8,
  parameter int PRIO_OFS = 3,
  parameter int PRIO_W   = 8,
  parameter int LINEAR   = 0,
  parameter int SAT      = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cen,
  input  logic          start,
  input  logic          abort,
  output logic          BRn,
  input  logic          BGn,
  output logic          BGACKn,
  output logic [AW-1:0] dma_addr,
  input  logic [15:0]   dma_din,
  output logic [15:0]   dma_dout,
  output logic          dma_we,
  output logic [1:0]    dma_dsn,
  input  logic          bus_busy,
  output logic          busy,
  output logic          done
);

  localparam int SW  = $clog2(ENTRIES);
  localparam int STW = $clog2(STRIDE);
  localparam logic [PRIO_W-1:0] LAST_LEVEL =
    (LINEAR != 0) ? {PRIO_W{1'b1}} : PRIO_W'(1) << (PRIO_W - 1);

  state_t            state, state_nx;
  logic [SW-1:0]     scan;
  logic [PRIO_W-1:0] level, hw_prio;
  logic [7:0]        cap;
  logic [AW-1:0]     rec_base;
  logic              grant, abort_go, restart, fin_step;
  logic              step, match, last_rec, last_level;
  logic              rd_go, cap_go, wr_go, wr_end, nx_go;
  logic              unused_din;

  assign unused_din = ^dma_din[7:0];
  assign step       = cen && !BGACKn;
  assign match      = (cap == 8'(level));
  assign last_rec   = &scan;
  assign last_level = (level == LAST_LEVEL);
  assign rec_base   = AW'(scan) << STW;
  assign fin_step   = (state == FIN) && step && !abort_go;

  jtriders_objdma_arb u_arb (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .abort    (abort),
    .BGn      (BGn),
    .fin_step (fin_step),
    .state    (state),
    .BRn      (BRn),
    .BGACKn   (BGACKn),
    .busy     (busy),
    .grant    (grant),
    .abort_go (abort_go),
    .restart  (restart)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (abort_go) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nx = REQ;
        REQ:     if (grant) state_nx = RD;
        RD:      if (step) state_nx = WT;
        WT:      if (step && !bus_busy) state_nx = CMP;
        CMP:     if (step) state_nx = match ? WR : NX;
        WR:      if (step) state_nx = NX;
        NX:      if (step) state_nx = (last_rec && last_level) ? FIN : RD;
        FIN:     if (step) state_nx = restart ? REQ : IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    rd_go  = 1'b0;
    cap_go = 1'b0;
    wr_go  = 1'b0;
    wr_end = 1'b0;
    nx_go  = 1'b0;
    if (step && !abort_go) begin
      case (state)
        RD:      rd_go  = 1'b1;
        WT:      cap_go = !bus_busy;
        CMP:     wr_go  = match;
        WR:      wr_end = 1'b1;
        NX:      nx_go  = 1'b1;
        default: ;
      endcase
    end
  end

  // Bus outputs and scan counters; abort and pass end always drop the strobes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dma_addr <= '0;
      dma_dout <= '0;
      dma_we   <= 1'b0;
      dma_dsn  <= DSN_NONE;
      done     <= 1'b0;
      scan     <= '0;
      level    <= '0;
      hw_prio  <= '0;
      cap      <= '0;
    end else begin
      done <= fin_step;
      if (abort_go || fin_step) begin
        dma_we  <= 1'b0;
        dma_dsn <= DSN_NONE;
      end
      if (grant) begin
        scan    <= '0;
        level   <= PRIO_W'(1);
        hw_prio <= PRIO_W'(1);
      end
      if (rd_go) begin
        dma_addr <= rec_base | AW'(PRIO_OFS);
        dma_dsn  <= DSN_BOTH;
        dma_we   <= 1'b0;
      end
      if (cap_go) cap <= dma_din[15:8];
      if (wr_go) begin
        dma_addr <= rec_base;
        dma_dsn  <= DSN_LO;
        dma_we   <= 1'b1;
        dma_dout <= {2{8'(hw_prio)}};
      end
      if (wr_end) begin
        dma_we  <= 1'b0;
        dma_dsn <= DSN_NONE;
        if (!((SAT != 0) && (&hw_prio))) hw_prio <= hw_prio + 1'b1;
      end
      if (nx_go) begin
        scan <= scan + 1'b1;
        if (last_rec) level <= (LINEAR != 0) ? level + 1'b1 : level << 1;
      end
    end
  end

endmodule
